// File: rtl/delay_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : delay_share_ctrl
// Purpose  : Round-robin time-sharing of one matched delay line among N
//            four-phase requesters, with latency measurement and timeout.
// Revision : 1.0
// ============================================================================
module delay_share_ctrl #(
   parameter int N    = 4,
   parameter int SYNC = 2,
   parameter int TW   = 8,
   parameter int TMO  = 200
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   output logic [N-1:0]         ack,
   output logic                 dly_i,
   input  logic                 dly_o,
   output logic                 busy,
   output logic [$clog2(N)-1:0] gnt_id,
   output logic [TW-1:0]        lat,
   output logic                 err,
   input  logic                 clr_err
);

   localparam int                c_IW   = $clog2(N);
   localparam logic [c_IW:0]     c_N    = (c_IW+1)'(N);
   localparam logic [c_IW-1:0]   c_LAST = c_IW'(N-1);
   localparam logic [N-1:0]      c_ONE  = N'(1);
   localparam logic [TW-1:0]     c_TMO  = TW'(TMO);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LAUNCH = 2'd1,
      S_ACKED  = 2'd2,
      S_RTZ    = 2'd3
   } state_t;

   state_t             r_state, w_state;
   logic [SYNC-1:0]    r_sync;
   logic [N-1:0]       r_ack, w_ack;
   logic               r_dly, w_dly;
   logic [c_IW-1:0]    r_gnt, w_gnt;
   logic [c_IW-1:0]    r_rr, w_rr;
   logic [TW-1:0]      r_lat, w_lat;
   logic [TW-1:0]      r_cnt, w_cnt;
   logic               r_err, w_err;
   logic               w_ds;
   logic               w_found;
   logic [c_IW-1:0]    w_win;
   logic [c_IW-1:0]    w_idx;
   logic [c_IW:0]      w_sum;
   logic [c_IW-1:0]    w_rr_next;

   // Only the synchronized return w_ds is ever looked at by the FSM.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_sync <= '0;
      else      r_sync <= {r_sync[SYNC-2:0], dly_o};
   end
   assign w_ds = r_sync[SYNC-1];

   // Round-robin search starting at the pointer, wrapping at N-1.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_sum   = '0;
      w_idx   = '0;
      for (int i = 0; i < N; i++) begin
         w_sum = {1'b0, r_rr} + (c_IW+1)'(i);
         w_idx = (w_sum >= c_N) ? c_IW'(w_sum - c_N) : w_sum[c_IW-1:0];
         if (!w_found && req[w_idx]) begin
            w_found = 1'b1;
            w_win   = w_idx;
         end
      end
   end

   assign w_rr_next = (r_gnt == c_LAST) ? '0 : r_gnt + 1'b1;

   always_comb begin
      w_state = r_state;
      w_ack   = r_ack;
      w_dly   = r_dly;
      w_gnt   = r_gnt;
      w_rr    = r_rr;
      w_lat   = r_lat;
      w_cnt   = r_cnt;
      w_err   = r_err & ~clr_err;
      case (r_state)
         S_IDLE: begin
            if (w_found && !w_ds) begin
               w_gnt   = w_win;
               w_dly   = 1'b1;
               w_cnt   = '0;
               w_state = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            w_cnt = r_cnt + 1'b1;
            if (w_ds) begin
               w_ack   = c_ONE << r_gnt;
               w_lat   = r_cnt;
               w_state = S_ACKED;
            end else if (r_cnt == c_TMO) begin
               // Fail open so the requester's handshake can still finish.
               w_err   = 1'b1;
               w_ack   = c_ONE << r_gnt;
               w_lat   = '1;
               w_state = S_ACKED;
            end
         end
         S_ACKED: begin
            if (!req[r_gnt]) begin
               w_ack   = '0;
               w_dly   = 1'b0;
               w_cnt   = '0;
               w_state = S_RTZ;
            end
         end
         S_RTZ: begin
            w_cnt = r_cnt + 1'b1;
            if (!w_ds) begin
               w_rr    = w_rr_next;
               w_state = S_IDLE;
            end else if (r_cnt == c_TMO) begin
               w_err   = 1'b1;
               w_rr    = w_rr_next;
               w_state = S_IDLE;
            end
         end
         default: w_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_ack   <= '0;
         r_dly   <= 1'b0;
         r_gnt   <= '0;
         r_rr    <= '0;
         r_lat   <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state;
         r_ack   <= w_ack;
         r_dly   <= w_dly;
         r_gnt   <= w_gnt;
         r_rr    <= w_rr;
         r_lat   <= w_lat;
         r_cnt   <= w_cnt;
         r_err   <= w_err;
      end
   end

   assign ack    = r_ack;
   assign dly_i  = r_dly;
   assign busy   = (r_state != S_IDLE);
   assign gnt_id = r_gnt;
   assign lat    = r_lat;
   assign err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_delay_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_delay_share_ctrl
// Purpose  : Directed self-checking bench for delay_share_ctrl (N=4, SYNC=2).
// Revision : 1.0
// ============================================================================
module tb_delay_share_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] req = '0;
   logic [3:0] ack;
   logic       dly_i;
   logic       dly_o;
   logic       busy;
   logic [1:0] gnt_id;
   logic [7:0] lat;
   logic       err;
   logic       clr_err = 1'b0;

   int         nerr = 0;
   int         nchk = 0;
   int         mode = 0;        // 0 loopback, 1 ten-cycle delay, 2 stuck 0, 3 stuck 1
   logic [9:0] hist = '0;
   logic       multi_ack = 1'b0;
   bit         ok;

   delay_share_ctrl #(.N(4), .SYNC(2), .TW(8), .TMO(200)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .ack     (ack),
      .dly_i   (dly_i),
      .dly_o   (dly_o),
      .busy    (busy),
      .gnt_id  (gnt_id),
      .lat     (lat),
      .err     (err),
      .clr_err (clr_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) hist <= {hist[8:0], dly_i};

   always_comb begin
      dly_o = 1'b0;
      case (mode)
         0:       dly_o = dly_i;
         1:       dly_o = hist[9];
         3:       dly_o = 1'b1;
         default: dly_o = 1'b0;
      endcase
   end

   always @(negedge clk) if ($countones(ack) > 1) multi_ack <= 1'b1;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ack(input logic [3:0] mask, input int budget, output bit got);
      got = 1'b0;
      for (int n = 0; n < budget && !got; n++) begin
         tick(1);
         if ((ack & mask) != 4'b0) got = 1'b1;
      end
   endtask

   task automatic wait_idle(input int budget, output bit got);
      got = 1'b0;
      for (int n = 0; n < budget && !got; n++) begin
         tick(1);
         if (!busy) got = 1'b1;
      end
   endtask

   task automatic grant(input int idx, input logic [7:0] exp_lat, input string tag);
      bit g;
      req[idx] = 1'b1;
      wait_ack(4'b0001 << idx, 300, g);
      chk({tag, "_ack_seen"}, 32'(g), 32'd1);
      chk({tag, "_gnt"}, 32'(gnt_id), 32'(idx));
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      req[idx] = 1'b0;
      wait_idle(300, g);
      chk({tag, "_idle"}, 32'(g), 32'd1);
   endtask

   initial begin
      // Reset state
      tick(2);
      chk("rst_ack", 32'(ack), 32'h0);
      chk("rst_dly_i", 32'(dly_i), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_gnt", 32'(gnt_id), 32'h0);
      chk("rst_lat", 32'(lat), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      rst = 1'b1;
      tick(2);

      // 1: zero-delay loopback, requester 1
      req = 4'b0010;
      tick(1);
      chk("t1_dly_i_up", 32'(dly_i), 32'h1);
      chk("t1_gnt", 32'(gnt_id), 32'h1);
      chk("t1_busy", 32'(busy), 32'h1);
      tick(2);
      chk("t1_ack_early", 32'(ack), 32'h0);
      tick(1);
      chk("t1_ack", 32'(ack), 32'h2);
      chk("t1_lat", 32'(lat), 32'h2);
      req = 4'b0000;
      tick(1);
      chk("t1_ack_down", 32'(ack), 32'h0);
      chk("t1_dly_i_down", 32'(dly_i), 32'h0);
      tick(2);
      chk("t1_busy_rtz", 32'(busy), 32'h1);
      tick(1);
      chk("t1_busy_down", 32'(busy), 32'h0);

      // 2: ten-cycle delay line, same requester twice
      tick(15);
      mode = 1;
      grant(0, 8'd12, "t2a");
      grant(0, 8'd12, "t2b");

      // Move the pointer back to 0 with a loopback grant on requester 3
      mode = 0;
      tick(15);
      grant(3, 8'd2, "t2c");

      // 3: all requesting, round-robin order 0,1,2,3,0
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_ack(4'b1111, 50, ok);
         chk("t3_ack_seen", 32'(ok), 32'd1);
         chk("t3_ack_onehot", 32'(ack), 32'(4'b0001 << (k % 4)));
         chk("t3_gnt", 32'(gnt_id), 32'(k % 4));
         req[k % 4] = 1'b0;
         tick(1);
         req[k % 4] = 1'b1;
      end
      req = 4'b0000;
      wait_idle(50, ok);
      chk("t3_idle", 32'(ok), 32'd1);
      chk("t3_never_two_acks", 32'(multi_ack), 32'd0);

      // 4: dead line, launch timeout (pointer now at 1)
      mode = 2;
      req = 4'b0010;
      tick(1);
      chk("t4_dly_i_up", 32'(dly_i), 32'h1);
      tick(200);
      chk("t4_ack_before_tmo", 32'(ack), 32'h0);
      chk("t4_err_before_tmo", 32'(err), 32'h0);
      tick(1);
      chk("t4_ack_tmo", 32'(ack), 32'h2);
      chk("t4_err_tmo", 32'(err), 32'h1);
      chk("t4_lat_ff", 32'(lat), 32'hFF);
      req = 4'b0000;
      wait_idle(20, ok);
      chk("t4_idle", 32'(ok), 32'd1);
      chk("t4_err_sticky", 32'(err), 32'h1);
      clr_err = 1'b1;
      tick(1);
      clr_err = 1'b0;
      chk("t4_err_cleared", 32'(err), 32'h0);

      // 5: line stuck high after the grant (pointer now at 2)
      mode = 0;
      req = 4'b0100;
      wait_ack(4'b0100, 20, ok);
      chk("t5_ack_seen", 32'(ok), 32'd1);
      chk("t5_lat", 32'(lat), 32'h2);
      mode = 3;
      req = 4'b0000;
      tick(1);
      chk("t5_rtz_busy", 32'(busy), 32'h1);
      chk("t5_rtz_err0", 32'(err), 32'h0);
      wait_idle(250, ok);
      chk("t5_rtz_timeout_idle", 32'(ok), 32'd1);
      chk("t5_rtz_err", 32'(err), 32'h1);
      req = 4'b1000;
      tick(5);
      chk("t5_held_busy", 32'(busy), 32'h0);
      chk("t5_held_dly_i", 32'(dly_i), 32'h0);
      mode = 0;
      wait_ack(4'b1000, 20, ok);
      chk("t5_late_grant", 32'(ok), 32'd1);
      chk("t5_late_gnt", 32'(gnt_id), 32'h3);
      req = 4'b0000;
      wait_idle(20, ok);
      chk("t5_idle", 32'(ok), 32'd1);

      // 6: asynchronous reset with ack[2] high and err still set
      req = 4'b0100;
      wait_ack(4'b0100, 20, ok);
      chk("t6_ack2", 32'(ack), 32'h4);
      #2;
      rst = 1'b0;
      #1;
      chk("t6_async_ack", 32'(ack), 32'h0);
      chk("t6_async_dly_i", 32'(dly_i), 32'h0);
      chk("t6_async_busy", 32'(busy), 32'h0);
      chk("t6_async_err", 32'(err), 32'h0);
      req = 4'b0000;
      tick(2);
      rst = 1'b1;
      tick(1);

      // After release: first grant from 0, and req dropped before ack
      req = 4'b1111;
      tick(1);
      chk("t6_first_gnt", 32'(gnt_id), 32'h0);
      chk("t6_first_dly_i", 32'(dly_i), 32'h1);
      req = 4'b0000;
      tick(2);
      chk("t6_viol_no_ack_yet", 32'(ack), 32'h0);
      tick(1);
      chk("t6_viol_ack_pulse", 32'(ack), 32'h1);
      tick(1);
      chk("t6_viol_ack_drop", 32'(ack), 32'h0);
      chk("t6_viol_gnt", 32'(gnt_id), 32'h0);
      wait_idle(20, ok);
      chk("t6_idle", 32'(ok), 32'd1);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
`default_nettype wire
